// File: rtl/ysyx_22050243_pkg.sv
// Shared definitions for the ysyx_22050243 core: ALU operation codes, datapath width, exec-stage state.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package ysyx_22050243_pkg;

  localparam int unsigned XLEN = 64;

  // alu_ctrl encoding shared with the ID-stage ALU control decoder
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_ADDW = 4'b1001;
  localparam logic [3:0] ALU_SUBW = 4'b1010;
  localparam logic [3:0] ALU_SLLW = 4'b1011;
  localparam logic [3:0] ALU_SRLW = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_SRAW = 4'b1110;
  localparam logic [3:0] ALU_ILL  = 4'b1111;

  // Occupancy of the single-entry exec output register
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } exec_state_t;

  // Sign-extend a 32-bit W-op result to the full datapath width
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22050243_alu_core.sv
// RV64I integer ALU datapath: (ctrl, a, b) -> (result, err).
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller registers and handshakes the result.
module ysyx_22050243_alu_core
  import ysyx_22050243_pkg::*;
(
  input  logic [3:0]      ctrl_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            err_o
);

  logic [5:0]      shamt;
  logic [4:0]      shamt_w;
  logic [31:0]     a_w;
  logic [31:0]     sum_w;
  logic [31:0]     diff_w;
  logic [31:0]     sll_w;
  logic [31:0]     srl_w;
  logic [31:0]     sra_w;
  logic [XLEN-1:0] sra_d;
  logic            lt_s;
  logic            lt_u;

  // 64-bit shifts take 6 amount bits, W shifts only 5 (upper bit ignored)
  assign shamt   = b_i[5:0];
  assign shamt_w = b_i[4:0];
  assign a_w     = a_i[31:0];

  assign sum_w  = a_w + b_i[31:0];
  assign diff_w = a_w - b_i[31:0];
  assign sll_w  = a_w << shamt_w;
  assign srl_w  = a_w >> shamt_w;
  assign sra_w  = $unsigned($signed(a_w) >>> shamt_w);
  assign sra_d  = $unsigned($signed(a_i) >>> shamt);
  assign lt_s   = $signed(a_i) < $signed(b_i);
  assign lt_u   = a_i < b_i;

  // Operation select; illegal code yields zero with the error flag set
  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (ctrl_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = sra_d;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_ADDW: result_o = sext32(sum_w);
      ALU_SUBW: result_o = sext32(diff_w);
      ALU_SLLW: result_o = sext32(sll_w);
      ALU_SRLW: result_o = sext32(srl_w);
      ALU_SRAW: result_o = sext32(sra_w);
      default: begin
        result_o = '0;
        err_o    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22050243_alu_exec.sv
// Execute-stage ALU with a single-entry registered output and valid/ready on both sides.
// Latency: 1 cycle from accept to out_valid; one op per cycle while out_ready is high.
// Backpressure: in_ready drops while the entry is held (out_valid && !out_ready) or during flush.
module ysyx_22050243_alu_exec #(
  parameter int unsigned XLEN = ysyx_22050243_pkg::XLEN,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_alu_ctrl,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [TAGW-1:0] out_tag,
  output logic            out_err
);

  import ysyx_22050243_pkg::*;

  exec_state_t     state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] core_result;
  logic            core_err;
  logic            accept;

  ysyx_22050243_alu_core u_core (
    .ctrl_i   (in_alu_ctrl),
    .a_i      (in_a),
    .b_i      (in_b),
    .result_o (core_result),
    .err_o    (core_err)
  );

  assign out_valid  = (state_q == S_FULL);
  assign in_ready   = !flush && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign out_result = result_q;
  assign out_tag    = tag_q;
  assign out_err    = err_q;

  // Next state: flush beats accept beats drain; data only loads on accept so stalls hold it
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    tag_d    = tag_q;
    err_d    = err_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else if (accept) begin
      state_d  = S_FULL;
      result_d = core_result;
      tag_d    = in_tag;
      err_d    = core_err;
    end else if (out_ready) begin
      state_d = S_EMPTY;
    end
  end

  // State and output register; reset clears everything, including a stalled entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_EMPTY;
      result_q <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      tag_q    <= tag_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_alu_exec.sv
// Self-checking bench for ysyx_22050243_alu_exec: directed vectors, scoreboard queue, monitor.
// Stimulus pushes expected results on accept; the monitor pops on every out_valid && out_ready.
// Direct checks cover reset, stall stability, flush and reset mid-stall.
module tb_ysyx_22050243_alu_exec;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_ctrl;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_tag;
  logic        out_err;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    logic        err;
    int          due;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  ysyx_22050243_alu_exec #(.XLEN(64), .TAGW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_alu_ctrl (in_alu_ctrl),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_err     (out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Monitor: every completed output transfer must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_out: got result %h tag %0d with empty scoreboard", out_result, out_tag);
        end else begin
          e = sb.pop_front();
          check("result", out_result, e.res);
          check("tag", out_tag, e.tag);
          check("err", out_err, e.err);
          if (e.chk_lat) check("latency", cyc, e.due);
        end
      end
    end
  end

  // Call at posedge+#1; holds the op until accepted, returns at posedge+#1 after accept
  task automatic issue(input logic [3:0] ctrl, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag, input logic [63:0] res, input logic err,
                       input bit push, input bit lat);
    exp_t e;
    bit   done;
    in_valid = 1'b1; in_alu_ctrl = ctrl; in_a = a; in_b = b; in_tag = tag;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) begin
          e.res = res; e.tag = tag; e.err = err; e.due = cyc + 1; e.chk_lat = lat;
          sb.push_back(e);
        end
        done = 1'b1;
      end
    end
    if (!done) begin
      n_chk++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 for tag %0d", tag);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait until the monitor has consumed every expectation; returns at posedge+#1
  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_alu_ctrl = 4'b0; in_a = '0; in_b = '0; in_tag = '0;

    // Reset for two cycles, then idle outputs
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Back-to-back with latency checks
    issue(4'b0000, 64'd5, -64'sd3, 5'd3, 64'd2, 1'b0, 1'b1, 1'b1);
    issue(4'b1000, 64'd0, 64'd1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1);
    // W ops
    issue(4'b1001, 64'h7FFF_FFFF, 64'd1, 5'd10, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 1'b1);
    issue(4'b1110, 64'h8000_0000, 64'd36, 5'd11, 64'hFFFF_FFFF_F800_0000, 1'b0, 1'b1, 1'b1);
    issue(4'b1011, 64'd1, 64'd31, 5'd12, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 1'b1);
    issue(4'b1100, 64'hFFFF_FFFF_8000_0000, 64'd4, 5'd13, 64'h0000_0000_0800_0000, 1'b0, 1'b1, 1'b1);
    issue(4'b1010, 64'd0, 64'd1, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1);
    // Compare, shift, logic
    issue(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd15, 64'd1, 1'b0, 1'b1, 1'b1);
    issue(4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd16, 64'd0, 1'b0, 1'b1, 1'b1);
    issue(4'b1101, 64'h8000_0000_0000_0000, 64'd63, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1);
    issue(4'b0101, 64'h8000_0000_0000_0000, 64'd63, 5'd18, 64'd1, 1'b0, 1'b1, 1'b1);
    issue(4'b0001, 64'd1, 64'd68, 5'd19, 64'd16, 1'b0, 1'b1, 1'b1);
    issue(4'b0100, 64'hF0F0, 64'hFF00, 5'd20, 64'h0FF0, 1'b0, 1'b1, 1'b1);
    issue(4'b0110, 64'hF0, 64'h0F, 5'd21, 64'hFF, 1'b0, 1'b1, 1'b1);
    issue(4'b0111, 64'hF0F0, 64'hFF00, 5'd22, 64'hF000, 1'b0, 1'b1, 1'b1);
    // Illegal code completes normally with err set
    issue(4'b1111, 64'h1234, 64'h5678, 5'd9, 64'd0, 1'b1, 1'b1, 1'b1);
    drain();

    // Backpressure: hold A for 3 cycles with B offered, then drain+accept together
    out_ready = 1'b0;
    issue(4'b0000, 64'd10, 64'd20, 5'd1, 64'd30, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b1; in_alu_ctrl = 4'b0000; in_a = 64'd1; in_b = 64'd1; in_tag = 5'd2;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_result", out_result, 64'd30);
      check("stall_tag", out_tag, 5'd1);
      check("stall_err", out_err, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("drain_accept_in_ready", in_ready, 1);
    e.res = 64'd2; e.tag = 5'd2; e.err = 1'b0; e.due = cyc + 1; e.chk_lat = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1 in_valid = 1'b0;
    drain();

    // Flush while full and stalled; op offered during flush must not be taken
    out_ready = 1'b0;
    issue(4'b0000, 64'd2, 64'd3, 5'd4, 64'd5, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; in_alu_ctrl = 4'b0000; in_a = 64'd7; in_b = 64'd7; in_tag = 5'd6;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    check("flush_full_before", out_valid, 1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    @(negedge clk);
    check("flush_no_accept", out_valid, 0);
    @(posedge clk); #1;

    // Reset mid-stall discards the held entry
    out_ready = 1'b0;
    issue(4'b0110, 64'hAA, 64'h55, 5'd31, 64'hFF, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_out_result", out_result, 0);
    check("rst2_out_tag", out_tag, 0);
    check("rst2_in_ready", in_ready, 1);
    @(posedge clk); #1 out_ready = 1'b1;

    // Final op after recovery, then everything must be consumed
    issue(4'b0000, 64'd100, 64'd23, 5'd8, 64'd123, 1'b0, 1'b1, 1'b1);
    drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
